// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply, restoring divide, sign fixup in a final cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               zdiv_q, zdiv_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               dz_q, dz_d, ovf_q, ovf_d, err_q, err_d;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b, ma, mb;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    abs_a     = a[WIDTH-1] ? -a : a;
    abs_b     = b[WIDTH-1] ? -b : b;
    ma        = signed_op ? abs_a : a;
    mb        = signed_op ? abs_b : b;

    // Multiply: low half holds the multiplier, upper half accumulates.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, low half shifts quotient bits in.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_next  = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    prod      = neg_q ? -acc_q : acc_q;
    quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    zdiv_d     = zdiv_q;
    ovf_pend_d = ovf_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d   = op[1];
              acc_d      = op[1] ? {{WIDTH{1'b0}}, ma} : {{WIDTH{1'b0}}, mb};
              opnd_d     = op[1] ? mb : ma;
              a_raw_d    = a;
              neg_d      = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d     = signed_op & a[WIDTH-1];
              zdiv_d     = (b == '0);
              ovf_pend_d = (op == OP_DIV) && (a == MOST_NEG) && (b == '1);
              cnt_d      = CW'(WIDTH);
              busy_d     = 1'b1;
              dz_d       = 1'b0;
              ovf_d      = 1'b0;
              state_d    = S_CALC;
            end
            OP_MTHI: hi_d  = a;
            OP_MTLO: lo_d  = a;
            default: err_d = 1'b1;
          endcase
        end
      end
      S_CALC: begin
        err_d = start;
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        err_d = start;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (zdiv_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        dz_d    = is_div_q & zdiv_q;
        ovf_d   = is_div_q & ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      zdiv_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      zdiv_q     <= zdiv_d;
      ovf_pend_q <= ovf_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: directed and random ops against a 64-bit arithmetic model.
// Handshake: start is sampled at a rising edge; done pulses one cycle when hi/lo update.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic         clk, rst_n, start;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, dz, ovf, err;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz), .ovf(ovf), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] av,
                                        input logic [31:0] bv, output logic edz,
                                        output logic eovf);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(av);
    sb = $signed(bv);
    edz = 1'b0;
    eovf = 1'b0;
    p = '0;
    case (o)
      3'd0: begin q = sa * sb; p = q; end
      3'd1: p = {32'b0, av} * {32'b0, bv};
      3'd2, 3'd3: begin
        if (bv == 32'd0) begin
          edz = 1'b1;
          p = {av, 32'hFFFF_FFFF};
        end else if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          eovf = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
          p = {r[31:0], q[31:0]};
        end else begin
          p = {av % bv, av / bv};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // driver: one mult/div; inj>=0 injects a start after that many cycles
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int inj);
    logic [63:0] e, prev;
    logic edz, eovf;
    int n, nbusy;
    bit stable, got;
    e = model(o, av, bv, edz, eovf);
    exp_q.push_back(e);
    prev = {hi, lo};
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0; nbusy = 0; stable = 1'b1; got = 1'b0;
    if (busy) nbusy++;
    while (n < 100 && !got) begin
      if (n == inj) begin
        start = 1'b1;
        op = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
      n++;
      if (n - 1 == inj) begin
        start = 1'b0;
        check("err_on_busy_start", {63'b0, err}, 64'd1);
      end
      if (busy) nbusy++;
      if (done) got = 1'b1;
      else if ({hi, lo} !== prev) stable = 1'b0;
    end
    check("latency", 64'(n), 64'(W + 1));
    check("busy_cycles", 64'(nbusy), 64'(W + 1));
    check("hilo_held", {63'b0, stable}, 64'd1);
    check("hi_lo", {hi, lo}, exp_q.pop_front());
    check("dz_ovf", {62'b0, dz, ovf}, {62'b0, edz, eovf});
    @(posedge clk); #1;
    check("done_pulse", {63'b0, done}, 64'd0);
  endtask

  task automatic mtx(input logic [2:0] o, input logic [31:0] val);
    logic [63:0] prev;
    prev = {hi, lo};
    @(negedge clk);
    start = 1'b1; op = o; a = val;
    @(posedge clk); #1;
    start = 1'b0;
    check(o == 3'd4 ? "mthi" : "mtlo", {hi, lo},
          o == 3'd4 ? {val, prev[31:0]} : {prev[63:32], val});
    check("mtx_flags", {61'b0, done, busy, err}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] prev;
    int gotdone;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {59'b0, busy, done, dz, ovf, err}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(3'd0, 32'hFFFF_FFF9, 32'd3, -1);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd3, 32'd100, 32'd7, -1);
    run_op(3'd3, 32'h1234, 32'd0, -1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 5);
    run_op(3'd1, 32'h0001_0003, 32'h0000_0100, 12);
    run_op(3'd3, 32'hDEAD_BEEF, 32'h0000_1234, W);

    mtx(3'd5, 32'hA5A5_A5A5);
    mtx(3'd4, 32'h5A5A_0F0F);

    prev = {hi, lo};
    @(negedge clk);
    start = 1'b1; op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("reserved_err", {61'b0, err, busy, done}, 64'd4);
    check("reserved_hilo", {hi, lo}, prev);
    @(posedge clk); #1;
    check("reserved_err_clear", {63'b0, err}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 3)), pick(), pick(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1);
    end

    // reset in the middle of a MULT
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF1, -1);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_abort_hilo", {hi, lo}, 64'd0);
    check("reset_abort_flags", {62'b0, busy, done}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    gotdone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) gotdone++;
    end
    check("no_done_after_abort", 64'(gotdone), 64'd0);
    run_op(3'd3, 32'd1000, 32'd33, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the combinational MIPS ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It is generalised to a parametrised datapath width and uses a start/busy/done handshake. It sits beside the ALU in the execute stage, and MFHI/MFLO read its hi/lo outputs directly.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=4). Iteration counter width is ceil(log2(WIDTH))+1, derived internally.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled at rising clk
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=reserved
a  in  WIDTH  multiplicand/dividend; MTHI/MTLO source
b  in  WIDTH  multiplier/divisor
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)
busy  out  1  high while a mult/div is in flight
done  out  1  one-cycle pulse when a mult/div result is written to hi/lo
dz  out  1  divide-by-zero flag, valid with done
ovf  out  1  signed-divide overflow flag, valid with done
err  out  1  one-cycle pulse: start rejected (busy or reserved op)

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, dz=0, ovf=0, err=0, FSM=IDLE, counter=0. Reset mid-operation aborts the operation; hi/lo return to 0 and no done pulse follows.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, op 0-3:
  - Latch |a|, |b| (MULT/DIV) or raw a, b (MULTU/DIVU).
  - Latch the result signs.
  - Load counter=WIDTH; set busy=1 on the same edge; go to CALC.
- IDLE, start=1, op 4/5: write a into hi (MTHI) or lo (MTLO) on that edge. Single cycle: no busy, no done.
- IDLE, start=1, op 6/7: no state change; err=1 for the next cycle.
- Any state but IDLE, start=1: request ignored; err=1 for one cycle; the in-flight op is unaffected.
- CALC: one step per cycle, counter decrements; leave to FIX after exactly WIDTH steps.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing WIDTH quotient bits and the remainder.
- FIX (1 cycle):
  - Apply sign correction:
    - MULT: product negated if sign(a)^sign(b).
    - DIV: quotient negated if signs differ; remainder takes the sign of the dividend (truncate toward zero).
  - Write hi/lo.
  - done=1, busy=0, dz/ovf updated, all on that edge; return to IDLE.
- Latency: start accepted at edge 0 → hi/lo valid and done=1 after edge WIDTH+1.
  - busy is high for cycles 1..WIDTH+1 (between edge 0 and edge WIDTH+1).
  - hi/lo hold their previous values until edge WIDTH+1.
- Back-to-back: start is legal in the cycle done=1 (FSM is IDLE).
- dz and ovf are cleared at each accepted mult/div start; they hold their value after done until the next accepted start.
- Divide by zero (b=0, DIV or DIVU): lo={WIDTH{1}}, hi=a (original operand, signed or not), dz=1. Full latency still applies.
- Signed overflow (DIV, a=1<<(WIDTH-1), b=all ones): lo=1<<(WIDTH-1), hi=0, ovf=1.
- MULT of most-negative × most-negative gives the exact 2*WIDTH result 1<<(2*WIDTH-2); no overflow is possible for multiply.
- hi/lo change only on FIX, MTHI/MTLO, or reset.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → done at edge 33; hi=0xFFFFFFFE lo=0x00000001; busy high exactly 33 cycles.
- MULT a=-7 (0xFFFFFFF9) b=3 → hi=0xFFFFFFFF lo=0xFFFFFFEB. MULT 0x80000000×0x80000000 → hi=0x40000000 lo=0.
- DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 → lo=14, hi=2, dz=0, ovf=0.
- DIVU a=0x1234 b=0 → lo=0xFFFFFFFF, hi=0x1234, dz=1. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0, ovf=1.
- start during busy (any op) → err pulse, result of first op unchanged. MTLO a=0xA5A5A5A5 in IDLE → lo updated next edge, done stays 0. op=7 → err pulse only.
- rst_n low at cycle 10 of a MULT → hi=lo=0, busy=0 immediately; no done. A new DIVU after release completes normally.
